hydra_router: RTL and testbench
===============================

// Module: hydra_router
// PURPOSE
// - Parametrised N-port Hydra packet router, successor to the fixed 4-UART hydra controller.
// - Sits between the per-port UART rx/tx buffers and comms_ctrl/shared FIFO.
// - Arbitrates ingress round-robin and delivers local config packets to comms_ctrl.
// - Forwards foreign packets through a bypass FIFO and multicasts egress to masked ports.
// - Interleaves forwarded traffic fairly with local FIFO data.
// PARAMETERS
// WIDTH       64   packet width incl. parity; router carries WIDTH-1 bits
// NUM_PORTS   4    Hydra ports (2..8)
// FWD_DEPTH   8    bypass FIFO depth, power of 2, >=2
// GLOBAL_ID   8'hFF broadcast chip id
// PORTS
// clk                    in   1              master clock
// reset_n_clk            in   1              async active-low reset
// rx_data                in   NUM_PORTS*(WIDTH-1) port p at [p*(WIDTH-1)+:WIDTH-1]
// rx_empty               in   NUM_PORTS      high: port has no packet
// uld_rx_data            out  NUM_PORTS      1-clk unload pulse to port
// enable_posi            in   NUM_PORTS      ingress enable mask
// enable_piso_upstream   in   NUM_PORTS      egress mask, upstream-bound
// enable_piso_downstream in   NUM_PORTS      egress mask, downstream-bound
// tx_busy                in   NUM_PORTS      port serializer busy
// ld_tx_data             out  NUM_PORTS      1-clk load pulse per target port
// tx_data                out  WIDTH-1        egress packet, valid while ld_tx_data high
// chip_id                in   8              this chip's id
// local_data             out  WIDTH-1        packet for comms_ctrl
// local_flag             out  1              1-clk pulse, local_data valid
// comms_busy             in   1              comms_ctrl cannot accept
// fifo_data              in   WIDTH-1        head of shared event FIFO
// fifo_valid             in   1              shared FIFO non-empty
// fifo_ack               out  1              1-clk pop pulse to shared FIFO
// fwd_level              out  $clog2(FWD_DEPTH)+1 bypass FIFO occupancy
// discard_count          out  16             saturating count of unroutable packets
// BEHAVIOUR
// - Reset: all outputs 0, FSMs idle, RR pointer=0, bypass FIFO empty, egress fairness bit=0.
// - Classify (hydra_pkg): type=[1:0], id=[9:2]; config = type[1]=1.
//   - LOCAL: config & (id==chip_id | id==GLOBAL_ID).
//   - FWD_DN: config & id!=chip_id (incl. global) -> downstream mask.
//   - FWD_UP: type[1]=0 -> upstream mask.
// - Ingress FSM I_IDLE->I_CLASS->I_LOCAL/I_ENQ->I_IDLE.
//   - I_IDLE: pick first p from RR pointer with !rx_empty[p]&enable_posi[p]; latch data, pulse uld_rx_data[p], pointer=p+1 mod NUM_PORTS.
//   - I_CLASS: route the packet.
//   - I_LOCAL: wait !comms_busy, pulse local_flag; then I_ENQ if global, else I_IDLE.
//   - I_ENQ: if target mask==0, discard_count++ (saturate 16'hFFFF), I_IDLE; else stall until FIFO not full, push {dir,data}, I_IDLE.
//   - No packet is ever dropped for lack of space; ingress backpressures instead.
// - Egress FSM E_IDLE->E_WAIT->E_LOAD->E_IDLE.
//   - Sources: bypass head and shared FIFO (upstream mask). If both ready, serve the source not served last (fairness bit); else serve whichever is ready.
//   - Empty egress mask: local source is held (no ack); forward entry is popped and counted as a discard.
//   - E_WAIT: hold until all targeted tx_busy low; mask re-sampled each cycle.
//   - E_LOAD: drive tx_data, pulse ld_tx_data=mask for 1 clk, same cycle pulse fifo_ack or pop bypass.
// - Latency: rx_empty low -> local_flag = 3 clks minimum; idle bypass entry -> ld_tx_data = 2 clks minimum.
// - Push and pop in the same cycle when full are legal; fwd_level is unchanged.
// - Async reset mid-packet aborts all state. A packet latched but undelivered is lost.
// STRUCTURE
// - hydra_pkg: pkt_type_t enum, field position localparams, route_t {LOCAL,FWD_UP,FWD_DN}.
// - Sub-module hydra_fwd_fifo: sync FIFO (WIDTH bits incl. dir), FWD_DEPTH deep, full/empty/level.
// TESTING
// - Reset: all outputs 0, fwd_level=0, discard_count=0.
// - chip_id=8'h12, write cfg id=12 on port 2: uld_rx_data=4'b0100, local_flag 3 clks later, no ld_tx_data.
// - Cfg id=FF on port0, down mask=4'b1010: local_flag, then ld_tx_data=4'b1010 once, tx_data matches.
// - Ports 0,1,3 all pending: unload order 0,1,3,0... round-robin; disabled port 2 is never unloaded.
// - Data pkts flood, up mask=4'b0001, tx_busy[0] stuck high: FIFO fills to 8, ingress stalls, zero drops; drains after release.
// - fifo_valid=1 plus bypass non-empty: egress alternates local/forward; empty mask bumps discard_count; saturation at 16'hFFFF.

Source files
------------

// File: rtl/hydra_pkg.sv
// Shared packet-format definitions for the Hydra router: header field positions,
// packet types, routing classes and the classifier used at ingress.
package hydra_pkg;

  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 2;
  localparam int ID_LSB   = 2;
  localparam int ID_W     = 8;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    PKT_DATA   = 2'b00,
    PKT_DATA_X = 2'b01,
    PKT_CFG    = 2'b10,
    PKT_CFG_X  = 2'b11
  } pkt_type_t;

  typedef enum logic [1:0] {
    ROUTE_LOCAL  = 2'd0,
    ROUTE_FWD_UP = 2'd1,
    ROUTE_FWD_DN = 2'd2
  } route_t;

  // Config packets addressed to us (or broadcast) are local; other config goes
  // downstream and plain data always heads upstream.
  function automatic route_t classify(input pkt_type_t typ, input logic [ID_W-1:0] id,
                                      input logic [ID_W-1:0] chip_id,
                                      input logic [ID_W-1:0] global_id);
    if (typ == PKT_DATA || typ == PKT_DATA_X) return ROUTE_FWD_UP;
    if (id == chip_id || id == global_id) return ROUTE_LOCAL;
    return ROUTE_FWD_DN;
  endfunction

endpackage

// File: rtl/hydra_fwd_fifo.sv
// Synchronous bypass FIFO holding {dir, packet} entries for forwarded traffic.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module hydra_fwd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n_clk,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hydra_router.sv
// Hydra N-port packet router: round-robin ingress, local config delivery to
// comms_ctrl, bypass forwarding and fair multicast egress against the shared FIFO.
module hydra_router
  import hydra_pkg::*;
#(
  parameter int         WIDTH     = 64,
  parameter int         NUM_PORTS = 4,
  parameter int         FWD_DEPTH = 8,
  parameter logic [7:0] GLOBAL_ID = 8'hFF
) (
  input  logic                             clk,
  input  logic                             reset_n_clk,
  input  logic [NUM_PORTS*(WIDTH-1)-1:0]   rx_data,
  input  logic [NUM_PORTS-1:0]             rx_empty,
  output logic [NUM_PORTS-1:0]             uld_rx_data,
  input  logic [NUM_PORTS-1:0]             enable_posi,
  input  logic [NUM_PORTS-1:0]             enable_piso_upstream,
  input  logic [NUM_PORTS-1:0]             enable_piso_downstream,
  input  logic [NUM_PORTS-1:0]             tx_busy,
  output logic [NUM_PORTS-1:0]             ld_tx_data,
  output logic [WIDTH-2:0]                 tx_data,
  input  logic [7:0]                       chip_id,
  output logic [WIDTH-2:0]                 local_data,
  output logic                             local_flag,
  input  logic                             comms_busy,
  input  logic [WIDTH-2:0]                 fifo_data,
  input  logic                             fifo_valid,
  output logic                             fifo_ack,
  output logic [$clog2(FWD_DEPTH):0]       fwd_level,
  output logic [15:0]                      discard_count
);
  localparam int DW = WIDTH - 1;
  localparam int PW = $clog2(NUM_PORTS);

  localparam logic [1:0] I_IDLE  = 2'd0;
  localparam logic [1:0] I_CLASS = 2'd1;
  localparam logic [1:0] I_LOCAL = 2'd2;
  localparam logic [1:0] I_ENQ   = 2'd3;

  localparam logic [1:0] E_IDLE  = 2'd0;
  localparam logic [1:0] E_WAIT  = 2'd1;
  localparam logic [1:0] E_LOAD  = 2'd2;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [DW-1:0]        rx_pkt [NUM_PORTS];
  logic [NUM_PORTS-1:0] rx_ready;
  logic [1:0]           i_state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        scan_idx;
  logic [PW-1:0]        pick_idx;
  logic                 pick_vld;
  logic [DW-1:0]        in_data;
  route_t               in_route;
  logic                 in_is_global;
  logic                 in_dir;
  logic [NUM_PORTS-1:0] in_mask;
  logic                 ing_disc;

  logic                 fwd_push;
  logic                 fwd_pop;
  logic [WIDTH-1:0]     fwd_rdata;
  logic                 fwd_full;
  logic                 fwd_empty;
  logic [NUM_PORTS-1:0] fwd_mask;

  logic [1:0]           e_state;
  logic                 e_sel_fwd;
  logic                 last_fwd;
  logic                 loc_rdy;
  logic                 e_pick_fwd;
  logic                 e_pick_loc;
  logic [NUM_PORTS-1:0] eg_mask;
  logic                 eg_disc;
  logic [1:0]           disc_inc;

  assign rx_ready = ~rx_empty & enable_posi;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) rx_pkt[p] = rx_data[p*DW +: DW];
  end

  // Scan downwards so the port closest to the pointer is the final winner.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_PORTS);
      if (rx_ready[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign in_route     = classify(pkt_type_t'(in_data[TYPE_LSB +: TYPE_W]),
                                 in_data[ID_LSB +: ID_W], chip_id, GLOBAL_ID);
  assign in_is_global = (in_data[ID_LSB +: ID_W] == GLOBAL_ID);
  assign in_dir       = (in_route == ROUTE_FWD_UP) ? DIR_UP : DIR_DN;
  assign in_mask      = (in_dir == DIR_DN) ? enable_piso_downstream : enable_piso_upstream;
  assign ing_disc     = (i_state == I_ENQ) && (in_mask == '0);
  assign fwd_push     = (i_state == I_ENQ) && (in_mask != '0) && (!fwd_full || fwd_pop);

  // Ingress FSM
  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      i_state     <= I_IDLE;
      rr_ptr      <= '0;
      uld_rx_data <= '0;
      local_flag  <= 1'b0;
      local_data  <= '0;
    end else begin
      uld_rx_data <= '0;
      local_flag  <= 1'b0;
      case (i_state)
        I_IDLE: begin
          if (pick_vld) begin
            uld_rx_data <= NUM_PORTS'(1) << pick_idx;
            rr_ptr      <= (pick_idx == PW'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
            i_state     <= I_CLASS;
          end
        end
        I_CLASS: i_state <= (in_route == ROUTE_LOCAL) ? I_LOCAL : I_ENQ;
        I_LOCAL: begin
          if (!comms_busy) begin
            local_flag <= 1'b1;
            local_data <= in_data;
            i_state    <= in_is_global ? I_ENQ : I_IDLE;
          end
        end
        I_ENQ: begin
          if (ing_disc || fwd_push) i_state <= I_IDLE;
        end
        default: i_state <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_state == I_IDLE && pick_vld) in_data <= rx_pkt[pick_idx];
  end

  hydra_fwd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FWD_DEPTH)
  ) u_fwd_fifo (
    .clk         (clk),
    .reset_n_clk (reset_n_clk),
    .push        (fwd_push),
    .wdata       ({in_dir, in_data}),
    .pop         (fwd_pop),
    .rdata       (fwd_rdata),
    .full        (fwd_full),
    .empty       (fwd_empty),
    .level       (fwd_level)
  );

  assign fwd_mask   = (fwd_rdata[WIDTH-1] == DIR_DN) ? enable_piso_downstream : enable_piso_upstream;
  assign loc_rdy    = fifo_valid && (enable_piso_upstream != '0);
  assign e_pick_fwd = !fwd_empty && (!loc_rdy || !last_fwd);
  assign e_pick_loc = loc_rdy && !e_pick_fwd;
  assign eg_mask    = e_sel_fwd ? fwd_mask : enable_piso_upstream;

  // A forward entry with nowhere to go is dropped; a local one simply waits.
  always_comb begin
    fwd_pop = 1'b0;
    eg_disc = 1'b0;
    case (e_state)
      E_IDLE: begin
        if (e_pick_fwd && fwd_mask == '0) begin
          fwd_pop = 1'b1;
          eg_disc = 1'b1;
        end
      end
      E_WAIT: begin
        if (e_sel_fwd && fwd_mask == '0) begin
          fwd_pop = 1'b1;
          eg_disc = 1'b1;
        end
      end
      E_LOAD:  fwd_pop = e_sel_fwd;
      default: ;
    endcase
  end

  // Egress FSM
  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      e_state    <= E_IDLE;
      e_sel_fwd  <= 1'b0;
      last_fwd   <= 1'b0;
      ld_tx_data <= '0;
      fifo_ack   <= 1'b0;
      tx_data    <= '0;
    end else begin
      ld_tx_data <= '0;
      fifo_ack   <= 1'b0;
      case (e_state)
        E_IDLE: begin
          if (e_pick_fwd && fwd_mask != '0) begin
            e_sel_fwd <= 1'b1;
            last_fwd  <= 1'b1;
            e_state   <= E_WAIT;
          end else if (e_pick_loc) begin
            e_sel_fwd <= 1'b0;
            last_fwd  <= 1'b0;
            e_state   <= E_WAIT;
          end
        end
        E_WAIT: begin
          if (eg_mask == '0) begin
            e_state <= E_IDLE;
          end else if ((eg_mask & tx_busy) == '0) begin
            ld_tx_data <= eg_mask;
            fifo_ack   <= !e_sel_fwd;
            tx_data    <= e_sel_fwd ? fwd_rdata[DW-1:0] : fifo_data;
            e_state    <= E_LOAD;
          end
        end
        E_LOAD:  e_state <= E_IDLE;
        default: e_state <= E_IDLE;
      endcase
    end
  end

  assign disc_inc = {1'b0, ing_disc} + {1'b0, eg_disc};

  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) discard_count <= '0;
    else if (disc_inc != 2'd0) discard_count <= sat_inc(discard_count, disc_inc);
  end

endmodule

// File: tb/tb_hydra_router.sv
// Directed bench for hydra_router: port buffer and shared-FIFO models feed the
// router, a negedge monitor logs pulses, and each step checks hand-computed values.
module tb_hydra_router;
  localparam int NP = 4;
  localparam int DW = 63;
  localparam int LW = 4;

  logic             clk = 1'b0;
  logic             reset_n_clk;
  logic [NP*DW-1:0] rx_data;
  logic [NP-1:0]    rx_empty;
  logic [NP-1:0]    uld_rx_data;
  logic [NP-1:0]    enable_posi;
  logic [NP-1:0]    enable_piso_upstream;
  logic [NP-1:0]    enable_piso_downstream;
  logic [NP-1:0]    tx_busy;
  logic [NP-1:0]    ld_tx_data;
  logic [DW-1:0]    tx_data;
  logic [7:0]       chip_id;
  logic [DW-1:0]    local_data;
  logic             local_flag;
  logic             comms_busy;
  logic [DW-1:0]    fifo_data;
  logic             fifo_valid;
  logic             fifo_ack;
  logic [LW-1:0]    fwd_level;
  logic [15:0]      discard_count;

  always #5 clk = ~clk;

  hydra_router #(
    .WIDTH     (64),
    .NUM_PORTS (NP),
    .FWD_DEPTH (8),
    .GLOBAL_ID (8'hFF)
  ) dut (
    .clk                    (clk),
    .reset_n_clk            (reset_n_clk),
    .rx_data                (rx_data),
    .rx_empty               (rx_empty),
    .uld_rx_data            (uld_rx_data),
    .enable_posi            (enable_posi),
    .enable_piso_upstream   (enable_piso_upstream),
    .enable_piso_downstream (enable_piso_downstream),
    .tx_busy                (tx_busy),
    .ld_tx_data             (ld_tx_data),
    .tx_data                (tx_data),
    .chip_id                (chip_id),
    .local_data             (local_data),
    .local_flag             (local_flag),
    .comms_busy             (comms_busy),
    .fifo_data              (fifo_data),
    .fifo_valid             (fifo_valid),
    .fifo_ack               (fifo_ack),
    .fwd_level              (fwd_level),
    .discard_count          (discard_count)
  );

  logic [DW-1:0] rxmem [NP][32];
  int            rxwr [NP] = '{default: 0};
  int            rxrd [NP] = '{default: 0};
  logic [DW-1:0] lmem [16];
  int            lwr = 0;
  int            lrd = 0;

  int            uldn = 0;
  int            uldlog [64];
  int            ldn = 0;
  logic [NP-1:0] ldmask_log [64];
  logic [DW-1:0] txlog [64];
  int            lfn = 0;
  logic [DW-1:0] lastlocal = '0;
  int            ackn = 0;

  int total = 0;
  int bad   = 0;

  always_comb begin
    rx_data  = '0;
    rx_empty = '1;
    for (int p = 0; p < NP; p++) begin
      rx_empty[p]         = (rxwr[p] == rxrd[p]);
      rx_data[p*DW +: DW] = rxmem[p][rxrd[p][4:0]];
    end
    fifo_valid = (lwr != lrd);
    fifo_data  = lmem[lrd[3:0]];
  end

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (uld_rx_data[p]) begin
        rxrd[p]            <= rxrd[p] + 1;
        uldlog[uldn[5:0]]  <= p;
        uldn               <= uldn + 1;
      end
    end
    if (ld_tx_data != '0) begin
      ldmask_log[ldn[5:0]] <= ld_tx_data;
      txlog[ldn[5:0]]      <= tx_data;
      ldn                  <= ldn + 1;
    end
    if (local_flag) begin
      lfn       <= lfn + 1;
      lastlocal <= local_data;
    end
    if (fifo_ack) begin
      lrd  <= lrd + 1;
      ackn <= ackn + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input int p, input logic [DW-1:0] d);
    rxmem[p][rxwr[p][4:0]] = d;
    rxwr[p] = rxwr[p] + 1;
  endtask

  task automatic push_local(input logic [DW-1:0] d);
    lmem[lwr[3:0]] = d;
    lwr = lwr + 1;
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0:       return ldn;
      1:       return lfn;
      default: return uldn;
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (cnt_of(which) < target && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, 64'(cnt_of(which) >= target), 64'd1);
  endtask

  function automatic logic [DW-1:0] cpkt(input logic [7:0] id, input logic [52:0] pl);
    return {pl, id, 2'b10};
  endfunction

  function automatic logic [DW-1:0] dpkt(input logic [52:0] pl);
    return {pl, 8'h00, 2'b00};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [3];
    logic [DW-1:0] p2, p3;
    seq = '{1, 3, 0};

    reset_n_clk            = 1'b0;
    enable_posi            = 4'b1111;
    enable_piso_upstream   = 4'b0000;
    enable_piso_downstream = 4'b0000;
    tx_busy                = 4'b0000;
    chip_id                = 8'h12;
    comms_busy             = 1'b0;
    tick(3);
    check("rst_uld", 64'(uld_rx_data), 64'h0);
    check("rst_ld", 64'(ld_tx_data), 64'h0);
    check("rst_tx_data", 64'(tx_data), 64'h0);
    check("rst_local_flag", 64'(local_flag), 64'h0);
    check("rst_local_data", 64'(local_data), 64'h0);
    check("rst_fifo_ack", 64'(fifo_ack), 64'h0);
    check("rst_fwd_level", 64'(fwd_level), 64'h0);
    check("rst_discard", 64'(discard_count), 64'h0);
    reset_n_clk = 1'b1;
    tick(2);

    // Local config packet on port 2
    p2 = cpkt(8'h12, 53'h1A2B);
    push_rx(2, p2);
    tick(1);
    check("t2_uld", 64'(uld_rx_data), 64'h4);
    check("t2_flag_early", 64'(local_flag), 64'h0);
    tick(1);
    check("t2_uld_pulse", 64'(uld_rx_data), 64'h0);
    tick(1);
    check("t2_local_flag", 64'(local_flag), 64'h1);
    check("t2_local_data", 64'(local_data), 64'(p2));
    tick(5);
    check("t2_no_ld", 64'(ldn), 64'd0);
    check("t2_flag_once", 64'(lfn), 64'd1);

    // Broadcast config on port 0: local delivery plus downstream multicast
    enable_piso_downstream = 4'b1010;
    p3 = cpkt(8'hFF, 53'h3C3C);
    push_rx(0, p3);
    wait_cnt(1, 2, 20, "t3_local_wait");
    wait_cnt(0, 1, 20, "t3_ld_wait");
    tick(5);
    check("t3_ld_once", 64'(ldn), 64'd1);
    check("t3_ld_mask", 64'(ldmask_log[0]), 64'hA);
    check("t3_tx_data", 64'(txlog[0]), 64'(p3));
    check("t3_local_data", 64'(lastlocal), 64'(p3));
    check("t3_port", 64'(uldlog[1]), 64'd0);
    check("t3_level", 64'(fwd_level), 64'd0);

    // Round-robin over ports 0,1,3 with port 2 disabled
    enable_posi            = 4'b1011;
    enable_piso_downstream = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      push_rx(0, cpkt(8'h12, 53'(16'h400 + k)));
      push_rx(1, cpkt(8'h12, 53'(16'h410 + k)));
      push_rx(3, cpkt(8'h12, 53'(16'h430 + k)));
    end
    push_rx(2, cpkt(8'h12, 53'h4FF));
    wait_cnt(1, 8, 100, "t4_local_wait");
    tick(4);
    check("t4_uld_count", 64'(uldn), 64'd8);
    for (int k = 0; k < 6; k++) check("t4_rr_order", 64'(uldlog[2+k]), 64'(seq[k%3]));
    check("t4_port2_idle", 64'(rxrd[2]), 64'd1);

    // Data flood into a blocked upstream port: bypass fills, ingress stalls
    enable_piso_upstream = 4'b0001;
    tx_busy              = 4'b0001;
    for (int k = 0; k < 11; k++) push_rx(seq[k%3], dpkt(53'(16'h500 + k)));
    tick(80);
    check("t5_full", 64'(fwd_level), 64'd8);
    check("t5_stall", 64'(uldn), 64'd17);
    check("t5_held", 64'(ldn), 64'd1);
    check("t5_no_drop", 64'(discard_count), 64'd0);
    tx_busy = 4'b0000;
    wait_cnt(0, 12, 200, "t5_drain_wait");
    tick(10);
    check("t5_drained", 64'(ldn), 64'd12);
    check("t5_uld_all", 64'(uldn), 64'd19);
    check("t5_level", 64'(fwd_level), 64'd0);
    check("t5_no_drop2", 64'(discard_count), 64'd0);
    check("t5_mask", 64'(ldmask_log[5]), 64'h1);
    for (int k = 0; k < 11; k++) check("t5_order", 64'(txlog[1+k]), 64'(dpkt(53'(16'h500 + k))));

    // Fair interleave of shared FIFO and bypass traffic
    tx_busy = 4'b0001;
    push_local(63'h7000_0000_0000_0A00);
    push_local(63'h7000_0000_0000_0A01);
    tick(2);
    push_rx(1, dpkt(53'h600));
    push_rx(1, dpkt(53'h601));
    tick(20);
    check("t6_level", 64'(fwd_level), 64'd2);
    tx_busy = 4'b0000;
    wait_cnt(0, 16, 100, "t6_wait");
    tick(5);
    check("t6_first_local", 64'(txlog[12]), 64'h7000_0000_0000_0A00);
    check("t6_then_fwd", 64'(txlog[13]), 64'(dpkt(53'h600)));
    check("t6_then_local", 64'(txlog[14]), 64'h7000_0000_0000_0A01);
    check("t6_then_fwd2", 64'(txlog[15]), 64'(dpkt(53'h601)));
    check("t6_acks", 64'(ackn), 64'd2);

    // Empty masks: ingress discard, egress discard, local held
    enable_piso_upstream = 4'b0000;
    push_rx(1, dpkt(53'h700));
    tick(15);
    check("t7_ing_discard", 64'(discard_count), 64'd1);
    check("t7_ing_level", 64'(fwd_level), 64'd0);
    enable_piso_upstream = 4'b0001;
    tx_busy              = 4'b0001;
    push_rx(1, dpkt(53'h710));
    push_rx(1, dpkt(53'h711));
    tick(20);
    check("t7_queued", 64'(fwd_level), 64'd2);
    enable_piso_upstream = 4'b0000;
    tick(6);
    check("t7_eg_discard", 64'(discard_count), 64'd3);
    check("t7_eg_level", 64'(fwd_level), 64'd0);
    check("t7_eg_no_ld", 64'(ldn), 64'd16);
    tx_busy = 4'b0000;
    push_local(63'h7000_0000_0000_0B00);
    tick(10);
    check("t7_local_held", 64'(ackn), 64'd2);
    check("t7_no_ld", 64'(ldn), 64'd16);
    enable_piso_upstream = 4'b0001;
    wait_cnt(0, 17, 20, "t7_release_wait");
    tick(3);
    check("t7_local_sent", 64'(txlog[16]), 64'h7000_0000_0000_0B00);
    check("t7_ack", 64'(ackn), 64'd3);

    // Discard counter saturation
    force dut.discard_count = 16'hFFFE;
    tick(1);
    release dut.discard_count;
    enable_piso_upstream = 4'b0000;
    push_rx(1, dpkt(53'h800));
    push_rx(1, dpkt(53'h801));
    push_rx(1, dpkt(53'h802));
    tick(25);
    check("t8_saturate", 64'(discard_count), 64'hFFFF);
    check("t8_uld", 64'(uldn), 64'd27);
    check("t8_no_ld", 64'(ldn), 64'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
